tx_hold_fifo_pkt: RTL and testbench

//  Parametrised, frame-aware TX hold FIFO for the XGMII transmit path.
//  - Buffers data+status words between the TX dequeue logic and the XGMII encoder.
//  - Adds a store-and-forward mode, atomic drop of frames that overflow, a

---
 rtl/xge_fifo_pkg.sv | 41 ++++
 rtl/tx_hold_fifo_ram.sv | 42 ++++
 rtl/tx_hold_fifo_pkt.sv | 216 +++++++++++++++++++++
 tb/tb_tx_hold_fifo_pkt.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_fifo_pkg.sv
// ---------------------------------------------------------------------------
// xge_fifo_pkg
// Shared definitions for the XGMII TX hold FIFO:
//   - bit positions inside the per-word status byte (SOP/EOP/ERR/lanes)
//   - fifo_word_t, the {status,data} word layout at the default 64/8 widths
//   - sf_state_t, the store-and-forward frame tracking states
//   - ptr_distance(), modulo distance between two wrapping FIFO pointers
// ---------------------------------------------------------------------------
package xge_fifo_pkg;

    localparam int STAT_SOP      = 7;
    localparam int STAT_EOP      = 6;
    localparam int STAT_ERR      = 5;
    localparam int STAT_LANES_HI = 2;
    localparam int STAT_LANES_LO = 0;

    localparam int DEF_DWIDTH = 64;
    localparam int DEF_SWIDTH = 8;

    typedef struct packed {
        logic [DEF_SWIDTH-1:0] status;
        logic [DEF_DWIDTH-1:0] data;
    } fifo_word_t;

    typedef enum logic [1:0] {
        SF_IDLE,
        SF_FRAME,
        SF_DISCARD
    } sf_state_t;

    // Pointers carry one extra wrap bit, so the distance is taken modulo
    // 2**(aw+1); the result is the number of words between tail and head.
    function automatic logic [31:0] ptr_distance(input logic [31:0] head,
                                                 input logic [31:0] tail,
                                                 input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (head - tail) & mask;
    endfunction

endpackage

// File: rtl/tx_hold_fifo_ram.sv
// ---------------------------------------------------------------------------
// tx_hold_fifo_ram
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (read register only)
//   we, waddr, wdata   write port
//   raddr        read address, sampled every clock
//   rdata        registered read data (old data on read-during-write)
// ---------------------------------------------------------------------------
module tx_hold_fifo_ram #(
    parameter int AWIDTH = 4,
    parameter int WIDTH  = 72
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(2**AWIDTH)-1];

    // Storage array has no reset; the FIFO pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register is cleared on reset so the head word reads as zero
    // until real data has been committed and fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tx_hold_fifo_pkt.sv
// ---------------------------------------------------------------------------
// tx_hold_fifo_pkt
// Frame-aware TX hold FIFO between the TX dequeue logic and the XGMII encoder.
// Cut-through (SF_MODE=0) or store-and-forward (SF_MODE=1) with atomic drop
// of frames that do not fit, a committed-frame count and an overflow counter.
// Ports:
//   clk_xgmii_tx / reset_xgmii_tx_n   clock, async active-low reset
//   txhfifo_wdata/wstatus/wen         write side
//   txhfifo_wfull/walmost_full        write-side flags
//   txhfifo_ren                       read/advance request
//   txhfifo_rdata/rstatus/rempty      first-word fall-through head word
//   txhfifo_ralmost_empty             committed occupancy <= AEMPTY_TH
//   txhfifo_rframes                   complete frames held
//   txhfifo_drop                      one-cycle pulse per discarded frame
//   txhfifo_ovf_cnt                   saturating count of lost words
// ---------------------------------------------------------------------------
module tx_hold_fifo_pkt
    import xge_fifo_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int SWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int SF_MODE   = 0,
    parameter int AEMPTY_TH = 7,
    parameter int AFULL_TH  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_xgmii_tx,
    input  logic                 reset_xgmii_tx_n,
    input  logic [DWIDTH-1:0]    txhfifo_wdata,
    input  logic [SWIDTH-1:0]    txhfifo_wstatus,
    input  logic                 txhfifo_wen,
    input  logic                 txhfifo_ren,
    output logic                 txhfifo_wfull,
    output logic                 txhfifo_walmost_full,
    output logic [DWIDTH-1:0]    txhfifo_rdata,
    output logic [SWIDTH-1:0]    txhfifo_rstatus,
    output logic                 txhfifo_rempty,
    output logic                 txhfifo_ralmost_empty,
    output logic [AWIDTH:0]      txhfifo_rframes,
    output logic                 txhfifo_drop,
    output logic [CNT_WIDTH-1:0] txhfifo_ovf_cnt
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE = (AWIDTH+1)'(1);

    logic [AWIDTH:0] wptr, cptr, rptr, fstart;
    logic [AWIDTH:0] wptr_next, cptr_next, rptr_next, fstart_next;
    sf_state_t       state, state_next;

    logic                     mem_we;
    logic [DWIDTH+SWIDTH-1:0] mem_rdata;
    logic                     do_read, drop_next, ovf_inc, frame_inc, frame_dec;
    logic                     wsop, weop;
    logic [31:0]              occ_w_next, occ_c_next;

    assign wsop      = txhfifo_wstatus[STAT_SOP];
    assign weop      = txhfifo_wstatus[STAT_EOP];
    assign do_read   = txhfifo_ren & ~txhfifo_rempty;
    assign rptr_next = do_read ? rptr + PTR_ONE : rptr;
    assign frame_dec = do_read & txhfifo_rstatus[STAT_EOP];

    assign occ_w_next = ptr_distance(32'(wptr_next), 32'(rptr_next), AWIDTH);
    assign occ_c_next = ptr_distance(32'(cptr_next), 32'(rptr_next), AWIDTH);

    // The RAM always fetches the word the head will point at after this
    // edge, which gives the one-cycle registered fall-through behaviour.
    tx_hold_fifo_ram #(
        .AWIDTH (AWIDTH),
        .WIDTH  (DWIDTH + SWIDTH)
    ) u_ram (
        .clk    (clk_xgmii_tx),
        .rst_n  (reset_xgmii_tx_n),
        .we     (mem_we),
        .waddr  (wptr[AWIDTH-1:0]),
        .wdata  ({txhfifo_wstatus, txhfifo_wdata}),
        .raddr  (rptr_next[AWIDTH-1:0]),
        .rdata  (mem_rdata)
    );

    assign txhfifo_rdata   = mem_rdata[DWIDTH-1:0];
    assign txhfifo_rstatus = mem_rdata[DWIDTH+SWIDTH-1:DWIDTH];

    // Write-side decision logic. In cut-through every accepted word is
    // committed at once. In store-and-forward, words are held uncommitted
    // until EOP; hitting full inside an open frame rolls the write pointer
    // back to the frame start and swallows the rest of that frame.
    always_comb begin
        wptr_next   = wptr;
        cptr_next   = cptr;
        fstart_next = fstart;
        state_next  = state;
        mem_we      = 1'b0;
        drop_next   = 1'b0;
        ovf_inc     = 1'b0;
        frame_inc   = 1'b0;
        if (SF_MODE == 0) begin
            if (txhfifo_wen) begin
                if (txhfifo_wfull) begin
                    ovf_inc = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    wptr_next = wptr + PTR_ONE;
                    frame_inc = weop;
                end
            end
            cptr_next = wptr_next;
        end else begin
            case (state)
                SF_IDLE: begin
                    if (txhfifo_wen) begin
                        if (!wsop || txhfifo_wfull) begin
                            ovf_inc = 1'b1;
                        end else begin
                            mem_we      = 1'b1;
                            wptr_next   = wptr + PTR_ONE;
                            fstart_next = wptr;
                            if (weop) begin
                                cptr_next = wptr + PTR_ONE;
                                frame_inc = 1'b1;
                            end else begin
                                state_next = SF_FRAME;
                            end
                        end
                    end
                end
                SF_FRAME: begin
                    if (txhfifo_wen) begin
                        if (txhfifo_wfull) begin
                            wptr_next  = fstart;
                            drop_next  = 1'b1;
                            ovf_inc    = 1'b1;
                            state_next = weop ? SF_IDLE : SF_DISCARD;
                        end else begin
                            mem_we    = 1'b1;
                            wptr_next = wptr + PTR_ONE;
                            if (wsop) begin
                                fstart_next = wptr;
                            end
                            if (weop) begin
                                cptr_next  = wptr + PTR_ONE;
                                frame_inc  = 1'b1;
                                state_next = SF_IDLE;
                            end
                        end
                    end
                end
                SF_DISCARD: begin
                    if (txhfifo_wen) begin
                        ovf_inc = 1'b1;
                        if (weop) begin
                            state_next = SF_IDLE;
                        end
                    end
                end
                default: state_next = SF_IDLE;
            endcase
        end
    end

    // Pointer and frame-tracking state registers.
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            wptr   <= '0;
            cptr   <= '0;
            rptr   <= '0;
            fstart <= '0;
            state  <= SF_IDLE;
        end else begin
            wptr   <= wptr_next;
            cptr   <= cptr_next;
            rptr   <= rptr_next;
            fstart <= fstart_next;
            state  <= state_next;
        end
    end

    // Registered flags. Fill-level flags follow the updated pointers; rempty
    // compares against the commit pointer from before the edge because the
    // RAM fetch for a word committed this edge only lands one edge later.
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            txhfifo_wfull         <= 1'b0;
            txhfifo_walmost_full  <= 1'b0;
            txhfifo_rempty        <= 1'b1;
            txhfifo_ralmost_empty <= 1'b1;
            txhfifo_drop          <= 1'b0;
        end else begin
            txhfifo_wfull         <= (occ_w_next == 32'(DEPTH));
            txhfifo_walmost_full  <= ((32'(DEPTH) - occ_w_next) <= 32'(AFULL_TH));
            txhfifo_rempty        <= (cptr == rptr_next);
            txhfifo_ralmost_empty <= (occ_c_next <= 32'(AEMPTY_TH));
            txhfifo_drop          <= drop_next;
        end
    end

    // Frame count nets a commit and a read of an EOP word in the same
    // cycle; the overflow counter sticks at all-ones.
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            txhfifo_rframes <= '0;
            txhfifo_ovf_cnt <= '0;
        end else begin
            if (frame_inc && !frame_dec) begin
                txhfifo_rframes <= txhfifo_rframes + PTR_ONE;
            end else if (!frame_inc && frame_dec) begin
                txhfifo_rframes <= txhfifo_rframes - PTR_ONE;
            end
            if (ovf_inc && (txhfifo_ovf_cnt != {CNT_WIDTH{1'b1}})) begin
                txhfifo_ovf_cnt <= txhfifo_ovf_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_hold_fifo_pkt.sv
// ---------------------------------------------------------------------------
// tb_tx_hold_fifo_pkt
// Directed bench for tx_hold_fifo_pkt. Three instances share one input
// stream: cut-through depth 16, store-and-forward depth 16 and
// store-and-forward depth 8. Each scenario resets first and then only
// examines the instance it targets.
// ---------------------------------------------------------------------------
module tb_tx_hold_fifo_pkt;
    import xge_fifo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] wdata;
    logic [7:0]  wstatus;
    logic        wen;
    logic        ren;

    logic        ct_wfull, ct_wafull, ct_rempty, ct_raempty, ct_drop;
    logic [63:0] ct_rdata;
    logic [7:0]  ct_rstatus;
    logic [4:0]  ct_rframes;
    logic [15:0] ct_ovf;

    logic        sf_wfull, sf_wafull, sf_rempty, sf_raempty, sf_drop;
    logic [63:0] sf_rdata;
    logic [7:0]  sf_rstatus;
    logic [4:0]  sf_rframes;
    logic [15:0] sf_ovf;

    logic        s3_wfull, s3_wafull, s3_rempty, s3_raempty, s3_drop;
    logic [63:0] s3_rdata;
    logic [7:0]  s3_rstatus;
    logic [3:0]  s3_rframes;
    logic [15:0] s3_ovf;

    int checks = 0;
    int passes = 0;

    tx_hold_fifo_pkt #(.AWIDTH(4), .SF_MODE(0)) dut_ct (
        .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n),
        .txhfifo_wdata(wdata), .txhfifo_wstatus(wstatus),
        .txhfifo_wen(wen), .txhfifo_ren(ren),
        .txhfifo_wfull(ct_wfull), .txhfifo_walmost_full(ct_wafull),
        .txhfifo_rdata(ct_rdata), .txhfifo_rstatus(ct_rstatus),
        .txhfifo_rempty(ct_rempty), .txhfifo_ralmost_empty(ct_raempty),
        .txhfifo_rframes(ct_rframes), .txhfifo_drop(ct_drop),
        .txhfifo_ovf_cnt(ct_ovf)
    );

    tx_hold_fifo_pkt #(.AWIDTH(4), .SF_MODE(1)) dut_sf (
        .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n),
        .txhfifo_wdata(wdata), .txhfifo_wstatus(wstatus),
        .txhfifo_wen(wen), .txhfifo_ren(ren),
        .txhfifo_wfull(sf_wfull), .txhfifo_walmost_full(sf_wafull),
        .txhfifo_rdata(sf_rdata), .txhfifo_rstatus(sf_rstatus),
        .txhfifo_rempty(sf_rempty), .txhfifo_ralmost_empty(sf_raempty),
        .txhfifo_rframes(sf_rframes), .txhfifo_drop(sf_drop),
        .txhfifo_ovf_cnt(sf_ovf)
    );

    tx_hold_fifo_pkt #(.AWIDTH(3), .SF_MODE(1)) dut_s3 (
        .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n),
        .txhfifo_wdata(wdata), .txhfifo_wstatus(wstatus),
        .txhfifo_wen(wen), .txhfifo_ren(ren),
        .txhfifo_wfull(s3_wfull), .txhfifo_walmost_full(s3_wafull),
        .txhfifo_rdata(s3_rdata), .txhfifo_rstatus(s3_rstatus),
        .txhfifo_rempty(s3_rempty), .txhfifo_ralmost_empty(s3_raempty),
        .txhfifo_rframes(s3_rframes), .txhfifo_drop(s3_drop),
        .txhfifo_ovf_cnt(s3_ovf)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k carries a recognisable data pattern; status has all lanes valid.
    function automatic fifo_word_t make_word(input int k, input bit sop, input bit eop);
        fifo_word_t w;
        w.data   = 64'hD000_0000_0000_0000 | 64'(k);
        w.status = {sop, eop, 3'b000, 3'b111};
        return w;
    endfunction

    // One clock of stimulus; returns 1 ns after the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input fifo_word_t word);
        wen     = w;
        ren     = r;
        wdata   = word.data;
        wstatus = word.status;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    fifo_word_t idle_w;

    initial begin
        idle_w  = '0;
        rst_n   = 1'b0;
        wen     = 1'b0;
        ren     = 1'b0;
        wdata   = '0;
        wstatus = '0;

        // Scenario 1: cut-through fill, overflow and in-order drain.
        $display("[TB] cut-through fill/drain");
        reset_all();
        checkOutput("rst_rempty",  64'(ct_rempty),  64'd1);
        checkOutput("rst_raempty", 64'(ct_raempty), 64'd1);
        checkOutput("rst_wfull",   64'(ct_wfull),   64'd0);
        checkOutput("rst_wafull",  64'(ct_wafull),  64'd0);
        checkOutput("rst_rdata",   ct_rdata,        64'd0);
        checkOutput("rst_rframes", 64'(ct_rframes), 64'd0);
        checkOutput("rst_ovf",     64'(ct_ovf),     64'd0);
        checkOutput("rst_drop",    64'(ct_drop),    64'd0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, k == 1, k == 16));
            if (k == 1)  checkOutput("ct_lat_e1", 64'(ct_rempty), 64'd1);
            if (k == 2) begin
                checkOutput("ct_lat_e2", 64'(ct_rempty), 64'd0);
                checkOutput("ct_lat_d",  ct_rdata, make_word(1, 1'b1, 1'b0).data);
            end
            if (k == 15) checkOutput("ct_wfull15", 64'(ct_wfull), 64'd0);
        end
        checkOutput("ct_wfull16",  64'(ct_wfull),   64'd1);
        checkOutput("ct_wafull16", 64'(ct_wafull),  64'd1);
        checkOutput("ct_rframes",  64'(ct_rframes), 64'd1);
        applyStimulus(1'b1, 1'b0, make_word(17, 1'b0, 1'b0));
        checkOutput("ct_ovf17",    64'(ct_ovf),     64'd1);
        checkOutput("ct_wfull17",  64'(ct_wfull),   64'd1);
        for (int k = 1; k <= 16; k++) begin
            checkOutput("ct_rd", ct_rdata, make_word(k, 1'b0, 1'b0).data);
            applyStimulus(1'b0, 1'b1, idle_w);
        end
        checkOutput("ct_rempty_end",  64'(ct_rempty),  64'd1);
        checkOutput("ct_rframes_end", 64'(ct_rframes), 64'd0);

        // Scenario 2: store-and-forward holds a frame until its EOP lands.
        $display("[TB] store-and-forward commit");
        reset_all();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, k == 1, k == 5));
            checkOutput("sf_hold_rempty", 64'(sf_rempty), 64'd1);
        end
        checkOutput("sf_rframes_eop", 64'(sf_rframes), 64'd1);
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("sf_rempty_vis", 64'(sf_rempty),  64'd0);
        checkOutput("sf_rstatus1",   64'(sf_rstatus), 64'h87);
        for (int k = 1; k <= 5; k++) begin
            checkOutput("sf_rd", sf_rdata, make_word(k, 1'b0, 1'b0).data);
            applyStimulus(1'b0, 1'b1, idle_w);
        end
        checkOutput("sf_rframes_end", 64'(sf_rframes), 64'd0);
        checkOutput("sf_rempty_end",  64'(sf_rempty),  64'd1);

        // Scenario 3: depth-8 store-and-forward, oversize frame is dropped.
        $display("[TB] oversize frame drop");
        reset_all();
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, k == 1, k == 12));
            if (k == 8) begin
                checkOutput("s3_wfull8", 64'(s3_wfull), 64'd1);
                checkOutput("s3_drop8",  64'(s3_drop),  64'd0);
            end
            if (k == 9) begin
                checkOutput("s3_drop9",  64'(s3_drop),  64'd1);
                checkOutput("s3_ovf9",   64'(s3_ovf),   64'd1);
                checkOutput("s3_wfull9", 64'(s3_wfull), 64'd0);
            end
            if (k == 10) checkOutput("s3_drop10", 64'(s3_drop), 64'd0);
        end
        checkOutput("s3_ovf_eop",    64'(s3_ovf),    64'd4);
        checkOutput("s3_rempty_eop", 64'(s3_rempty), 64'd1);
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("s3_rempty_after", 64'(s3_rempty),  64'd1);
        checkOutput("s3_rframes_drop", 64'(s3_rframes), 64'd0);
        for (int k = 21; k <= 23; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, k == 21, k == 23));
        end
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("s3_rempty_f2",  64'(s3_rempty),  64'd0);
        checkOutput("s3_rframes_f2", 64'(s3_rframes), 64'd1);
        for (int k = 21; k <= 23; k++) begin
            checkOutput("s3_rd", s3_rdata, make_word(k, 1'b0, 1'b0).data);
            applyStimulus(1'b0, 1'b1, idle_w);
        end
        checkOutput("s3_rempty_end", 64'(s3_rempty), 64'd1);
        applyStimulus(1'b1, 1'b0, make_word(30, 1'b0, 1'b0));
        checkOutput("s3_stray_ovf", 64'(s3_ovf), 64'd5);
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("s3_stray_rempty", 64'(s3_rempty), 64'd1);

        // Scenario 4: steady simultaneous read and write at occupancy 8.
        $display("[TB] simultaneous read/write");
        reset_all();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, 1'b0, 1'b0));
        end
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("rw_raempty0", 64'(ct_raempty), 64'd0);
        checkOutput("rw_wafull0",  64'(ct_wafull),  64'd0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("rw_head", ct_rdata, make_word(i + 1, 1'b0, 1'b0).data);
            applyStimulus(1'b1, 1'b1, make_word(i + 9, 1'b0, 1'b0));
            checkOutput("rw_raempty", 64'(ct_raempty), 64'd0);
        end
        checkOutput("rw_wafull", 64'(ct_wafull), 64'd0);
        checkOutput("rw_wfull",  64'(ct_wfull),  64'd0);
        checkOutput("rw_rempty", 64'(ct_rempty), 64'd0);
        for (int k = 21; k <= 28; k++) begin
            checkOutput("rw_drain", ct_rdata, make_word(k, 1'b0, 1'b0).data);
            applyStimulus(1'b0, 1'b1, idle_w);
        end
        checkOutput("rw_rempty_end", 64'(ct_rempty), 64'd1);

        // Scenario 5: reset dropped mid-frame, then a fresh frame.
        $display("[TB] reset mid-frame");
        reset_all();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, k == 1, 1'b0));
        end
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("mr_pre_rempty", 64'(ct_rempty), 64'd0);
        #3;
        rst_n = 1'b0;
        #2;
        checkOutput("mr_rempty",  64'(ct_rempty),  64'd1);
        checkOutput("mr_rdata",   ct_rdata,        64'd0);
        checkOutput("mr_raempty", 64'(ct_raempty), 64'd1);
        checkOutput("mr_wfull",   64'(ct_wfull),   64'd0);
        checkOutput("mr_sf_rempty", 64'(sf_rempty), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, make_word(40, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0, make_word(41, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("mr_ct_d40", ct_rdata, make_word(40, 1'b0, 1'b0).data);
        checkOutput("mr_sf_d40", sf_rdata, make_word(40, 1'b0, 1'b0).data);
        checkOutput("mr_sf_rframes", 64'(sf_rframes), 64'd1);
        applyStimulus(1'b0, 1'b1, idle_w);
        checkOutput("mr_ct_d41", ct_rdata, make_word(41, 1'b0, 1'b0).data);
        checkOutput("mr_sf_d41", sf_rdata, make_word(41, 1'b0, 1'b0).data);
        applyStimulus(1'b0, 1'b1, idle_w);
        checkOutput("mr_ct_empty", 64'(ct_rempty), 64'd1);
        checkOutput("mr_sf_empty", 64'(sf_rempty), 64'd1);

        // Scenario 6: almost-full / almost-empty thresholds on depth 16.
        $display("[TB] thresholds");
        reset_all();
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, 1'b0, 1'b0));
        end
        applyStimulus(1'b0, 1'b0, idle_w);
        checkOutput("th_raempty7", 64'(ct_raempty), 64'd1);
        checkOutput("th_wafull7",  64'(ct_wafull),  64'd0);
        applyStimulus(1'b1, 1'b0, make_word(8, 1'b0, 1'b0));
        checkOutput("th_raempty8", 64'(ct_raempty), 64'd0);
        for (int k = 9; k <= 11; k++) begin
            applyStimulus(1'b1, 1'b0, make_word(k, 1'b0, 1'b0));
        end
        checkOutput("th_wafull11", 64'(ct_wafull), 64'd0);
        applyStimulus(1'b1, 1'b0, make_word(12, 1'b0, 1'b0));
        checkOutput("th_wafull12", 64'(ct_wafull), 64'd1);
        applyStimulus(1'b0, 1'b1, idle_w);
        checkOutput("th_wafull_rd", 64'(ct_wafull), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
